// File: rtl/program_loader_if.sv
// Valid/ready instruction stream feeding the boot loader.
// master drives words into the loader; slave is the loader side.
interface program_loader_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/program_loader.sv
// Boot sequencer: streams a program into instruction memory with the core held in reset, then starts it.
// Optional checksum verification of the streamed program is enabled by defining LOADER_CHECKSUM_EN.
//
//  state | meaning
//  IDLE  | after reset, waiting for load_req
//  LOAD  | accepting words and writing them into IM
//  HOLD  | program written, core still held in reset for RST_CYCLES
//  START | core released, start raised
//  RUN   | core running, done raised
//  ERROR | load aborted (overflow or checksum mismatch)
module program_loader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int MAX_WORDS  = 1024,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req_i,
  program_loader_if.slave   in_if,
`ifdef LOADER_CHECKSUM_EN
  input  logic [DATA_W-1:0] expected_sum_i,
  output logic [DATA_W-1:0] checksum_o,
`endif
  output logic              im_en_write_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [DATA_W-1:0] im_data_o,
  output logic              cpu_reset_o,
  output logic              cpu_start_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int TW = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, START, RUN, ERROR} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              ready_q, cpu_reset_q, cpu_start_q, done_q, error_q;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign accept = in_if.valid & ready_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wl_d    = wl_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (load_req_i) begin
          state_d = LOAD;
          wl_d    = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          // words_loaded doubles as the write address counter
          wr_d   = 1'b1;
          addr_d = wl_q[ADDR_W-1:0];
          data_d = in_if.data;
          wl_d   = wl_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_if.data;
`endif
          if (in_if.last) begin
            timer_d = TW'(RST_CYCLES);
`ifdef LOADER_CHECKSUM_EN
            state_d = (sum_d == expected_sum_i) ? HOLD : ERROR;
`else
            state_d = HOLD;
`endif
          end else if (wl_q == LAST_IDX) begin
            state_d = ERROR;
          end
        end
      end
      HOLD: begin
        if (timer_q == '0) state_d = START;
        else               timer_d = timer_q - TW'(1);
      end
      START:   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      wl_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      ready_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      cpu_start_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wl_q        <= wl_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      // status outputs follow the state being entered so they stay registered yet aligned
      ready_q     <= (state_d == LOAD);
      cpu_reset_q <= !((state_d == START) || (state_d == RUN));
      cpu_start_q <= (state_d == START) || (state_d == RUN);
      done_q      <= (state_d == RUN);
      error_q     <= (state_d == ERROR);
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_if.ready    = ready_q;
  assign im_en_write_o  = wr_q;
  assign im_addr_o      = addr_q;
  assign im_data_o      = data_q;
  assign cpu_reset_o    = cpu_reset_q;
  assign cpu_start_o    = cpu_start_q;
  assign words_loaded_o = wl_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_o     = sum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a per-load reference model of writes, timing and outcome.
module tb_program_loader;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 16;
  localparam int MAX_WORDS  = 4;
  localparam int RST_CYCLES = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_req;
  logic              im_en_write;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_data;
  logic              cpu_reset, cpu_start, done, error;
  logic [ADDR_W:0]   words_loaded;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] expected_sum, checksum;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  logic [31:0] wr_log[$];
  logic [DATA_W-1:0] prog[8];
  int          prog_len;
  bit          prog_last;

  program_loader_if #(.DATA_W(DATA_W)) s_if();

  program_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_req_i     (load_req),
    .in_if          (s_if),
`ifdef LOADER_CHECKSUM_EN
    .expected_sum_i (expected_sum),
    .checksum_o     (checksum),
`endif
    .im_en_write_o  (im_en_write),
    .im_addr_o      (im_addr),
    .im_data_o      (im_data),
    .cpu_reset_o    (cpu_reset),
    .cpu_start_o    (cpu_start),
    .words_loaded_o (words_loaded),
    .done_o         (done),
    .error_o        (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (im_en_write === 1'b1) begin
      wr_log.push_back(32'({im_addr, im_data}));
      last_wr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_cpu_start"}, cpu_start, 0);
    check({tag, "_in_ready"},  s_if.ready, 0);
    check({tag, "_en_write"},  im_en_write, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_error"},     error, 0);
    check({tag, "_wl"},        words_loaded, 0);
    check({tag, "_addr"},      im_addr, 0);
  endtask

  // gap_mode: 0 none, 1 two idle cycles before every word after the first, 2 random gaps
  task automatic run_load(input int gap_mode, input bit sum_ok);
    bit                overflow;
    bit                exp_err;
    int                exp_wr;
    int                t;
    bit                acc;
    logic [DATA_W-1:0] s;
    logic [31:0]       exp_w;

    overflow = !prog_last;
    exp_wr   = overflow ? MAX_WORDS : prog_len;
    s = '0;
    for (int i = 0; i < exp_wr; i++) s = s + prog[i];
`ifdef LOADER_CHECKSUM_EN
    expected_sum = sum_ok ? s : s + DATA_W'($urandom_range(1, 16'hFFFF));
    exp_err = overflow || !sum_ok;
`else
    exp_err = overflow || (sum_ok && !sum_ok);
`endif
    wr_log.delete();

    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    @(negedge clk);
    check("load_in_ready", s_if.ready, 1);
    check("load_wl_clear", words_loaded, 0);
    check("load_cpu_reset", cpu_reset, 1);
    check("load_cpu_start", cpu_start, 0);
    check("load_done_clear", done, 0);
    check("load_error_clear", error, 0);

    for (int i = 0; i < prog_len; i++) begin
      if (i < exp_wr && ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
        s_if.valid = 1'b0;
        repeat (gap_mode == 1 ? 2 : $urandom_range(1, 3)) begin
          load_req = (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
        end
        load_req = 1'b0;
      end
      s_if.valid = 1'b1;
      s_if.data  = prog[i];
      s_if.last  = prog_last && (i == prog_len - 1);
      acc = 1'b0;
      for (t = 0; t < 6; t++) begin
        acc = s_if.ready;
        tick();
        if (acc) break;
      end
      if (i < exp_wr) check("word_accepted", acc, 1);
      else            check("overflow_word_refused", acc, 0);
      if (acc && s_if.last) begin
        s_if.valid = 1'b0;
        @(negedge clk);
        check("ready_drop_after_last", s_if.ready, 0);
      end
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;

    if (!exp_err) begin
      t = 0;
      while (cpu_reset !== 1'b0 && t < 40) begin @(negedge clk); t++; end
      check("reset_fall_delay", cyc - last_wr_cyc, RST_CYCLES + 1);
      check("start_at_release", cpu_start, 1);
      check("done_lags_start", done, 0);
      @(negedge clk);
      check("run_done", done, 1);
      check("run_cpu_start", cpu_start, 1);
      check("run_cpu_reset", cpu_reset, 0);
      check("run_error", error, 0);
    end else begin
      t = 0;
      while (error !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      check("err_error", error, 1);
      check("err_cpu_reset", cpu_reset, 1);
      check("err_cpu_start", cpu_start, 0);
      check("err_done", done, 0);
    end
    repeat (2) @(negedge clk);
    check("words_loaded", words_loaded, exp_wr);
    check("write_count", wr_log.size(), exp_wr);
    for (int i = 0; i < exp_wr && i < wr_log.size(); i++) begin
      exp_w = 32'({ADDR_W'(i), prog[i]});
      check("im_write", wr_log[i], exp_w);
    end
`ifdef LOADER_CHECKSUM_EN
    check("checksum", checksum, s);
`endif
  endtask

  task automatic reset_mid_load();
    prog_len = 4;
    for (int i = 0; i < 4; i++) prog[i] = DATA_W'($urandom);
    wr_log.delete();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = prog[i];
      s_if.last  = 1'b0;
      tick();
    end
    reset      = 1'b1;
    s_if.data  = prog[2];
    tick();
    @(negedge clk);
    check_reset_vals("midrst");
    tick();
    reset      = 1'b0;
    s_if.valid = 1'b0;
    repeat (4) tick();
    check("midrst_write_count", wr_log.size(), 2);
    check("midrst_idle_ready", s_if.ready, 0);
    check("midrst_idle_cpu_reset", cpu_reset, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    load_req   = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    expected_sum = '0;
`endif
    repeat (2) tick();
    @(negedge clk);
    check_reset_vals("por");
    tick();
    reset = 1'b0;

    prog[0] = 16'h4004; prog[1] = 16'h7000; prog[2] = 16'h4002;
    prog_len = 3; prog_last = 1'b1;
    run_load(0, 1'b1);

    prog[0] = 16'h0000; prog_len = 1; prog_last = 1'b1;
    run_load(0, 1'b1);

    prog[0] = 16'h2007; prog[1] = 16'h7400; prog_len = 2; prog_last = 1'b1;
    run_load(1, 1'b1);

    for (int i = 0; i < 5; i++) prog[i] = DATA_W'(16'h1000 + i);
    prog_len = MAX_WORDS + 1; prog_last = 1'b0;
    run_load(0, 1'b1);

    reset_mid_load();

`ifdef LOADER_CHECKSUM_EN
    prog[0] = 16'd1; prog[1] = 16'd2; prog[2] = 16'd3; prog_len = 3; prog_last = 1'b1;
    run_load(0, 1'b0);
    run_load(0, 1'b1);
`endif

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        prog_len  = MAX_WORDS + 1;
        prog_last = 1'b0;
      end else begin
        prog_len  = $urandom_range(1, MAX_WORDS);
        prog_last = 1'b1;
      end
      for (int i = 0; i < prog_len; i++) prog[i] = DATA_W'($urandom);
      run_load(2, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
